// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
package imem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [31:0] NOP_INSN        = 32'h0000_0013;
  localparam int          DEPTH_WORDS_DEF = 1024;
  localparam int          WAIT_CYCLES_DEF = 1;

endpackage

// File: rtl/imem_array.sv
// Word-addressed instruction storage with one synchronous read port and one
// write port; a same-edge read of the written word returns the old contents.
module imem_array
  import imem_pkg::*;
#(
  parameter int DEPTH_WORDS = DEPTH_WORDS_DEF
) (
  input  logic        clk,
  input  logic        rd_en,
  input  logic [29:0] rd_word,
  output logic [31:0] rd_data,
  input  logic        wr_en,
  input  logic [29:0] wr_word,
  input  logic [31:0] wr_data
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  logic [31:0] mem [DEPTH_WORDS];
  logic        rd_ok;
  logic        wr_ok;

  // Range checks use the full word address so truncation never aliases.
  assign rd_ok = {2'b00, rd_word} < 32'(DEPTH_WORDS);
  assign wr_ok = {2'b00, wr_word} < 32'(DEPTH_WORDS);

  always_ff @(posedge clk) begin
    if (rd_en && rd_ok) begin
      rd_data <= mem[rd_word[AW-1:0]];
    end
    if (wr_en && wr_ok) begin
      mem[wr_word[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/imem_responder.sv
// Single-outstanding instruction fetch responder: accepts one request, waits a
// fixed number of cycles, then presents the word until the fetch side takes it.
module imem_responder
  import imem_pkg::*;
#(
  parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        flush,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [31:0] rsp_addr,
  output logic        rsp_err,
  input  logic        ld_en,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data,
  output logic        busy
);

  // Handshakes: a transfer happens on a rising edge where valid && ready; the
  // sender holds its payload steady while valid is high and ready is low.

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  state_t      state;
  state_t      state_d;
  logic [3:0]  cnt;
  logic [3:0]  cnt_d;
  logic [31:0] addr_q;
  logic        err_q;
  logic        accept;
  logic        rd_en;
  logic        req_err;
  logic [29:0] rd_word;
  logic [31:0] rd_data;
  logic        unused_bits;

  assign unused_bits = &{1'b0, ld_addr[1:0]};

  assign req_err = (req_addr[1:0] != 2'b00) ||
                   ({2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS));

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    accept    = 1'b0;
    rd_en     = 1'b0;
    req_ready = (state == ST_IDLE) && !ld_en && !flush;
    unique case (state)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_d = ST_RESP;
            rd_en   = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt - 4'd1;
        if (flush) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt == 4'd1) begin
          state_d = ST_RESP;
          rd_en   = 1'b1;
        end
      end
      ST_RESP: begin
        // flush wins over rsp_ready; both simply retire the response.
        if (flush || rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= 4'd0;
      addr_q <= 32'd0;
      err_q  <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (accept) begin
        addr_q <= req_addr;
        err_q  <= req_err;
      end
    end
  end

  // With zero wait cycles the read happens on the accepting edge itself.
  assign rd_word = (state == ST_IDLE) ? req_addr[31:2] : addr_q[31:2];

  imem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk     (clk),
    .rd_en   (rd_en),
    .rd_word (rd_word),
    .rd_data (rd_data),
    .wr_en   (ld_en && !rst),
    .wr_word (ld_addr[31:2]),
    .wr_data (ld_data)
  );

  assign rsp_valid = (state == ST_RESP);
  assign rsp_err   = rsp_valid && err_q;
  assign rsp_addr  = rsp_valid ? addr_q : 32'd0;
  assign rsp_data  = !rsp_valid ? 32'd0 : (err_q ? NOP_INSN : rd_data);
  assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: a transaction-level reference model is
// compared every cycle, and literal expectations pin key transactions.
module tb_imem_responder;

  localparam int DEPTH = 1024;
  localparam int WAITC = 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = 32'd0;
  logic        flush = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic [31:0] rsp_addr;
  logic        rsp_err;
  logic        ld_en = 1'b0;
  logic [31:0] ld_addr = 32'd0;
  logic [31:0] ld_data = 32'd0;
  logic        busy;

  imem_responder #(
    .DEPTH_WORDS(DEPTH),
    .WAIT_CYCLES(WAITC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .flush     (flush),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_addr  (rsp_addr),
    .rsp_err   (rsp_err),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .busy      (busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: one outstanding request, response after WAITC+1 cycles
  logic [31:0] mem_m [DEPTH];
  bit          m_live = 0;
  bit          m_pend = 0;
  bit          m_resp = 0;
  int          m_left = 0;
  logic [31:0] m_addr = 32'd0;
  logic [31:0] m_data = 32'd0;
  bit          m_err = 0;

  function automatic logic [31:0] fetch(input logic [31:0] a, input bit e);
    return e ? NOP : mem_m[a[11:2]];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_pend = 0;
      m_resp = 0;
      m_live = 1;
    end else begin
      if (m_resp) begin
        if (flush || rsp_ready) m_resp = 0;
      end else if (m_pend) begin
        if (flush) begin
          m_pend = 0;
        end else begin
          m_left--;
          if (m_left == 0) begin
            m_pend = 0;
            m_resp = 1;
            m_data = fetch(m_addr, m_err);
          end
        end
      end else if (req_valid && !ld_en && !flush) begin
        m_addr = req_addr;
        m_err  = (req_addr % 4 != 0) || (req_addr / 4 >= DEPTH);
        if (WAITC == 0) begin
          m_resp = 1;
          m_data = fetch(m_addr, m_err);
        end else begin
          m_pend = 1;
          m_left = WAITC;
        end
      end
      // write after the model's read: same-edge read sees old contents
      if (ld_en && (ld_addr / 4 < DEPTH)) mem_m[ld_addr / 4] = ld_data;
    end
  end

  // scoreboard compare, every cycle after the first reset edge
  always @(negedge clk) begin
    if (m_live) begin
      chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_resp});
      chk("rsp_data",  rsp_data, m_resp ? m_data : 32'd0);
      chk("rsp_addr",  rsp_addr, m_resp ? m_addr : 32'd0);
      chk("rsp_err",   {31'd0, rsp_err}, {31'd0, m_resp && m_err});
      chk("busy",      {31'd0, busy}, {31'd0, m_pend || m_resp});
      chk("req_ready", {31'd0, req_ready},
          {31'd0, !m_pend && !m_resp && !ld_en && !flush});
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    step();
    ld_en = 1'b0;
  endtask

  task automatic do_req(input string name, input logic [31:0] a,
                        input logic [31:0] d, input logic e);
    req_valid = 1'b1; req_addr = a; rsp_ready = 1'b1;
    step();
    req_valid = 1'b0;
    chk({name, "_busy_after_accept"}, {31'd0, busy}, 32'd1);
    chk({name, "_no_early_valid"}, {31'd0, rsp_valid}, 32'd0);
    step();
    chk({name, "_valid"}, {31'd0, rsp_valid}, 32'd1);
    chk({name, "_data"}, rsp_data, d);
    chk({name, "_addr"}, rsp_addr, a);
    chk({name, "_err"}, {31'd0, rsp_err}, {31'd0, e});
    step();
    chk({name, "_valid_drop"}, {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("reset_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_data", rsp_data, 32'd0);
    chk("reset_ready", {31'd0, req_ready}, 32'd1);

    load(32'h0000_0100, 32'hDEAD_BEEF);
    load(32'h0000_0000, 32'h1111_1111);
    load(32'h0000_0104, 32'hCAFE_F00D);
    load(32'h0000_010B, 32'h0000_0055);   // low bits ignored -> word 0x108
    load(32'h0000_1000, 32'hFFFF_FFFF);   // out of range, dropped

    do_req("basic", 32'h0000_0100, 32'hDEAD_BEEF, 1'b0);
    do_req("lowbits", 32'h0000_0108, 32'h0000_0055, 1'b0);
    do_req("oor_load", 32'h0000_0000, 32'h1111_1111, 1'b0);

    // hold response with rsp_ready low
    rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h0000_0104;
    step();
    req_valid = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
      chk("hold_data", rsp_data, 32'hCAFE_F00D);
      chk("hold_addr", rsp_addr, 32'h0000_0104);
      chk("hold_ready", {31'd0, req_ready}, 32'd0);
      step();
    end
    rsp_ready = 1'b1;
    step();
    chk("hold_release_busy", {31'd0, busy}, 32'd0);

    do_req("misalign", 32'h0000_0102, NOP, 1'b1);
    do_req("range", 32'(4 * DEPTH), NOP, 1'b1);

    // flush in WAIT
    req_valid = 1'b1; req_addr = 32'h0;
    step();
    req_valid = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_wait_busy", {31'd0, busy}, 32'd0);
    chk("flush_wait_valid", {31'd0, rsp_valid}, 32'd0);
    // flush in RESP together with rsp_ready
    req_valid = 1'b1; req_addr = 32'h0; rsp_ready = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    chk("flush_resp_pre_valid", {31'd0, rsp_valid}, 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_resp_busy", {31'd0, busy}, 32'd0);
    chk("flush_resp_valid", {31'd0, rsp_valid}, 32'd0);
    do_req("post_flush", 32'h0, 32'h1111_1111, 1'b0);

    // load to the in-flight word on the edge entering RESP
    req_valid = 1'b1; req_addr = 32'h0000_0104; rsp_ready = 1'b0;
    step();
    req_valid = 1'b0;
    ld_en = 1'b1; ld_addr = 32'h0000_0104; ld_data = 32'h0BAD_C0DE;
    step();
    ld_en = 1'b0;
    chk("rbw_old_data", rsp_data, 32'hCAFE_F00D);
    rsp_ready = 1'b1;
    step();
    do_req("rbw_new_data", 32'h0000_0104, 32'h0BAD_C0DE, 1'b0);

    // reset during WAIT
    req_valid = 1'b1; req_addr = 32'h0000_0100;
    step();
    req_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_wait_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("rst_wait_no_rsp", {31'd0, rsp_valid}, 32'd0);
      step();
    end
    do_req("mem_kept_a", 32'h0000_0100, 32'hDEAD_BEEF, 1'b0);
    do_req("mem_kept_b", 32'h0000_0000, 32'h1111_1111, 1'b0);

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, is the number of 32-bit instruction words stored.
REQ-002 Parameter WAIT_CYCLES, default 1, is the number of wait cycles between request acceptance and response (legal range 0..15).
REQ-003 Port: clk  in  1  the single clock; all logic is on its rising edge.
REQ-004 Port: rst  in  1  synchronous, active-high reset.
REQ-005 Port: req_valid  in  1  the fetch side presents a request.
REQ-006 Port: req_ready  out  1  the responder can accept a request this cycle.
REQ-007 Port: req_addr  in  32  byte address of the requested instruction.
REQ-008 Port: flush  in  1  redirect; discards any in-flight request.
REQ-009 Port: rsp_valid  out  1  response word is valid.
REQ-010 Port: rsp_ready  in  1  the fetch side consumes the response.
REQ-011 Port: rsp_data  out  32  instruction word.
REQ-012 Port: rsp_addr  out  32  byte address that produced rsp_data.
REQ-013 Port: rsp_err  out  1  the request was misaligned or out of range.
REQ-014 Port: ld_en  in  1  program-load write strobe.
REQ-015 Port: ld_addr  in  32  byte address of the load write.
REQ-016 Port: ld_data  in  32  load write data.
REQ-017 Port: busy  out  1  high whenever the FSM is not IDLE.

Function
REQ-018 The FSM SHALL have the states IDLE, WAIT and RESP.
REQ-019 req_ready SHALL equal (state==IDLE) && !ld_en && !flush.
REQ-020 A request SHALL be accepted on the edge where req_valid && req_ready, latching req_addr.
REQ-021 On acceptance the FSM SHALL go to WAIT and load the wait counter with WAIT_CYCLES.
REQ-022 If WAIT_CYCLES is 0, acceptance SHALL go directly to RESP.
REQ-023 In WAIT the counter SHALL decrement each cycle, and the FSM SHALL go to RESP on the edge where the counter is 1.
REQ-024 Latency: a request accepted at edge N SHALL show rsp_valid=1 in the cycle after edge N+1+WAIT_CYCLES-1, which is WAIT_CYCLES+1 cycles after acceptance.
REQ-025 The array read SHALL occur on the edge entering RESP, with read-before-write against a same-edge ld_en write.
REQ-026 In RESP, rsp_valid, rsp_data, rsp_addr and rsp_err SHALL stay stable until rsp_ready=1.
REQ-027 When rsp_ready=1 in RESP, the FSM SHALL return to IDLE on the next edge and rsp_valid SHALL drop.
REQ-028 Outstanding requests SHALL never exceed one; back-to-back throughput is one word per WAIT_CYCLES+2 cycles.
REQ-029 If req_addr[1:0]!=0 or req_addr[31:2]>=DEPTH_WORDS, the response SHALL have rsp_err=1 and rsp_data=32'h00000013 (NOP).
REQ-030 Otherwise the response SHALL have rsp_err=0 and rsp_data=mem[req_addr[31:2]].
REQ-031 flush=1 in WAIT or RESP SHALL return the FSM to IDLE on the next edge with rsp_valid=0, taking priority over rsp_ready.
REQ-032 A flush in RESP SHALL not count as a completed handshake.
REQ-033 flush in IDLE SHALL block acceptance in that cycle (see REQ-019).
REQ-034 ld_en=1 SHALL write ld_data to mem[ld_addr[31:2]] on the edge in any state.
REQ-035 An ld_en write whose address is out of range SHALL be ignored, and ld_addr[1:0] SHALL be ignored.
REQ-036 When unused, outputs SHALL be: rsp_data=0, rsp_addr=0, rsp_err=0 whenever rsp_valid=0.

Reset
REQ-037 rst=1 SHALL force state=IDLE, counter=0 and rsp_valid=rsp_err=0, rsp_data=rsp_addr=0 on the next edge, with busy=0 afterwards.
REQ-038 rst SHALL override flush, handshakes and ld_en, and a mid-transaction reset SHALL discard the request without a response.
REQ-039 Memory contents SHALL NOT be cleared by reset.

Structure
REQ-040 Package imem_pkg SHALL hold the state enum, the NOP constant 32'h00000013, and the defaults for DEPTH_WORDS and WAIT_CYCLES.
REQ-041 The storage SHALL be a sub-module imem_array: synchronous read, one write port, read-before-write.
REQ-042 FSM, counter and output registers SHALL reside in imem_responder.

Verification
REQ-043 Load 0x100=32'hDEADBEEF, then request 0x100 with WAIT_CYCLES=1 and rsp_ready=1 -> rsp_valid 2 cycles after accept, data DEADBEEF, rsp_addr 0x100, err 0.
REQ-044 Hold rsp_ready=0 for 5 cycles in RESP -> outputs stable and req_ready=0; raise rsp_ready -> IDLE next cycle.
REQ-045 Request 0x102, then request 4*DEPTH_WORDS -> both responses have rsp_err=1 and rsp_data=00000013.
REQ-046 Flush in WAIT, then flush in RESP while rsp_ready=1 -> no handshake, IDLE next cycle; a following request to 0x0 completes normally.
REQ-047 ld_en to the in-flight address on the edge entering RESP -> old data returned; a re-request returns new data.
REQ-048 Assert rst during WAIT -> no response, busy=0 next cycle, and previously loaded memory is intact.
